// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the PC onto the memory address bus and registers opcode/operand bytes.
// Optional two-byte (opcode + immediate) instruction support is enabled with `define FETCH_IMMEDIATE_EN.
module fetch_stage #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter logic [7:0]  NOP_OPCODE   = 8'h00,
    parameter int          DELAY_RISE   = 0,
    parameter int          DELAY_FALL   = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_mem_data,
    input  logic        i_stall,
    input  logic        i_branch_taken,
    input  logic [15:0] i_branch_target,
    output logic [15:0] o_mem_addr,
    output logic [7:0]  o_opcode_out,
    output logic [7:0]  o_operand_out,
    output logic        o_operand_valid
);

`ifdef FETCH_IMMEDIATE_EN
    typedef enum logic [0:0] {S_OPCODE = 1'b0, S_OPERAND = 1'b1} state_t;
`else
    typedef enum logic [0:0] {S_OPCODE = 1'b0} state_t;
`endif

    // Output delays belong to timing-annotated simulation models; the synthesizable core only validates them.
    if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_delay
        $error("fetch_stage: DELAY_RISE/DELAY_FALL must be non-negative");
    end

    state_t      r_state, w_state_next;
    logic [15:0] r_pc, w_pc_next;
    logic [7:0]  r_opcode, w_opcode_next;
    logic [7:0]  r_operand, w_operand_next;
    logic        r_operand_valid, w_operand_valid_next;

    // NOTE: every next-state signal gets a hold/default value first so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_next         = r_state;
        w_pc_next            = r_pc;
        w_opcode_next        = r_opcode;
        w_operand_next       = r_operand;
        w_operand_valid_next = 1'b0;

        if (i_branch_taken) begin
            // Any half-fetched two-byte instruction is abandoned; the last operand stays visible.
            w_pc_next     = i_branch_target;
            w_opcode_next = NOP_OPCODE;
            w_state_next  = S_OPCODE;
        end else if (!i_stall) begin
            w_pc_next = r_pc + 16'd1;
            case (r_state)
                S_OPCODE: begin
                    w_opcode_next = i_mem_data;
`ifdef FETCH_IMMEDIATE_EN
                    if (i_mem_data[7]) begin
                        w_state_next = S_OPERAND;
                    end
`endif
                end
`ifdef FETCH_IMMEDIATE_EN
                S_OPERAND: begin
                    w_operand_next       = i_mem_data;
                    w_operand_valid_next = 1'b1;
                    w_opcode_next        = NOP_OPCODE;
                    w_state_next         = S_OPCODE;
                end
`endif
                default: begin
                    w_state_next = S_OPCODE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= S_OPCODE;
            r_pc            <= RESET_VECTOR;
            r_opcode        <= NOP_OPCODE;
            r_operand       <= 8'h00;
            r_operand_valid <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_pc            <= w_pc_next;
            r_opcode        <= w_opcode_next;
            r_operand       <= w_operand_next;
            r_operand_valid <= w_operand_valid_next;
        end
    end

    assign o_mem_addr   = r_pc;
    assign o_opcode_out = r_opcode;

`ifdef FETCH_IMMEDIATE_EN
    assign o_operand_out   = r_operand;
    assign o_operand_valid = r_operand_valid;
`else
    // Without immediates the operand path is tied off; its registers only ever hold their reset values.
    assign o_operand_out   = 8'h00;
    assign o_operand_valid = 1'b0;

    logic w_unused_operand;
    assign w_unused_operand = ^{r_operand, r_operand_valid};
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; expectations adapt to whether FETCH_IMMEDIATE_EN is defined.
module tb_fetch_stage;

    localparam logic [15:0] RV  = 16'h0100;
    localparam logic [7:0]  NOP = 8'hEA;

`ifdef FETCH_IMMEDIATE_EN
    localparam bit IMM = 1'b1;
`else
    localparam bit IMM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  mem_data;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] mem_addr;
    logic [7:0]  opcode_out;
    logic [7:0]  operand_out;
    logic        operand_valid;

    logic [7:0]  mem [0:65535];

    int n_total = 0;
    int n_bad   = 0;

    fetch_stage #(
        .RESET_VECTOR(RV),
        .NOP_OPCODE  (NOP),
        .DELAY_RISE  (0),
        .DELAY_FALL  (0)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_mem_data     (mem_data),
        .i_stall        (stall),
        .i_branch_taken (branch_taken),
        .i_branch_target(branch_target),
        .o_mem_addr     (mem_addr),
        .o_opcode_out   (opcode_out),
        .o_operand_out  (operand_out),
        .o_operand_valid(operand_valid)
    );

    always #5 clk = ~clk;

    // Program memory answers combinationally for whatever address the stage presents.
    assign mem_data = mem[mem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [15:0] addr, input logic [7:0] opc,
                             input logic [7:0] opd, input logic vld);
        check({tag, ".addr"}, 32'(mem_addr), 32'(addr));
        check({tag, ".opc"}, 32'(opcode_out), 32'(opc));
        check({tag, ".opd"}, 32'(operand_out), 32'(opd));
        check({tag, ".vld"}, 32'(operand_valid), 32'(vld));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h01;
        mem[16'h0100] = 8'h05; mem[16'h0101] = 8'h06; mem[16'h0102] = 8'h07;
        mem[16'h0000] = 8'h82; mem[16'h0001] = 8'h3C; mem[16'h0002] = 8'h07;
        mem[16'h0010] = 8'h11; mem[16'h0011] = 8'h12;
        mem[16'h0020] = 8'h85; mem[16'h0021] = 8'h44;
        mem[16'h2000] = 8'h09; mem[16'h2001] = 8'h90; mem[16'h2002] = 8'h5A;
        mem[16'hFFFF] = 8'h0A;

        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
        step(); step();
        check_out("reset", RV, NOP, 8'h00, 1'b0);

        // Sequential fetch from the reset vector
        rst = 1'b0;
        step(); check_out("seq1", 16'h0101, 8'h05, 8'h00, 1'b0);
        step(); check_out("seq2", 16'h0102, 8'h06, 8'h00, 1'b0);

        // Two-byte instruction at 0000
        branch_taken = 1'b1; branch_target = 16'h0000;
        step(); check_out("br0", 16'h0000, NOP, 8'h00, 1'b0);
        branch_taken = 1'b0;
        step(); check_out("imm_op", 16'h0001, 8'h82, 8'h00, 1'b0);
        step();
        if (IMM) check_out("imm_arg", 16'h0002, NOP, 8'h3C, 1'b1);
        else     check_out("imm_arg", 16'h0002, 8'h3C, 8'h00, 1'b0);
        step(); check_out("imm_next", 16'h0003, 8'h07, IMM ? 8'h3C : 8'h00, 1'b0);

        // Three stall cycles at 0010, then resume
        branch_taken = 1'b1; branch_target = 16'h0010;
        step(); check_out("br10", 16'h0010, NOP, IMM ? 8'h3C : 8'h00, 1'b0);
        branch_taken = 1'b0; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); check_out($sformatf("stall%0d", i), 16'h0010, NOP, IMM ? 8'h3C : 8'h00, 1'b0);
        end
        stall = 1'b0;
        step(); check_out("resume", 16'h0011, 8'h11, IMM ? 8'h3C : 8'h00, 1'b0);

        // Branch beats stall while the operand byte is pending
        branch_taken = 1'b1; branch_target = 16'h0020;
        step(); check_out("br20", 16'h0020, NOP, IMM ? 8'h3C : 8'h00, 1'b0);
        branch_taken = 1'b0;
        step(); check_out("op85", 16'h0021, 8'h85, IMM ? 8'h3C : 8'h00, 1'b0);
        branch_taken = 1'b1; branch_target = 16'h2000; stall = 1'b1;
        step(); check_out("br_in_opnd", 16'h2000, NOP, IMM ? 8'h3C : 8'h00, 1'b0);
        branch_taken = 1'b0; stall = 1'b0;
        step(); check_out("after_br", 16'h2001, 8'h09, IMM ? 8'h3C : 8'h00, 1'b0);

        // Stall right after an operand pulse drops OPERAND_VALID but holds the byte
        step(); check_out("op90", 16'h2002, 8'h90, IMM ? 8'h3C : 8'h00, 1'b0);
        step();
        if (IMM) check_out("arg5a", 16'h2003, NOP, 8'h5A, 1'b1);
        else     check_out("arg5a", 16'h2003, 8'h5A, 8'h00, 1'b0);
        stall = 1'b1;
        step();
        if (IMM) check_out("stall_vld", 16'h2003, NOP, 8'h5A, 1'b0);
        else     check_out("stall_vld", 16'h2003, 8'h5A, 8'h00, 1'b0);
        stall = 1'b0;

        // PC wraps from FFFF to 0000
        branch_taken = 1'b1; branch_target = 16'hFFFF;
        step(); check_out("brFFFF", 16'hFFFF, NOP, IMM ? 8'h5A : 8'h00, 1'b0);
        branch_taken = 1'b0;
        step(); check_out("wrap", 16'h0000, 8'h0A, IMM ? 8'h5A : 8'h00, 1'b0);

        // Reset overrides branch and stall in the middle of a two-byte instruction
        step(); check_out("op82b", 16'h0001, 8'h82, IMM ? 8'h5A : 8'h00, 1'b0);
        rst = 1'b1; branch_taken = 1'b1; branch_target = 16'h3000; stall = 1'b1;
        step(); check_out("rst_mid", RV, NOP, 8'h00, 1'b0);
        rst = 1'b0; branch_taken = 1'b0; stall = 1'b0;
        step(); check_out("post_rst", 16'h0101, 8'h05, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
